uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmitter: small write FIFO feeding a start/data/parity/stop serializer.
// Each serial bit is timed by a down-counting baud timer that reloads at every bit boundary.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to hold a word
// START | driving the start bit (low)
// DATA  | shifting data bits out, LSB first
// PAR   | driving the parity bit (only reachable when PARITY != 0)
// STOP  | driving the stop bit(s) high; chains straight into START if more data is queued
module uart_tx_engine #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic              STOP_LAST   = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   tx_done_q, tx_done_d;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   next_frame;
    logic [DATA_BITS-1:0]   head;

    assign wr_ready = (count_q != FIFO_FULL);
    assign push     = wr_valid && wr_ready;
    assign head     = mem_q[rd_ptr_q];

    // Pointers wrap for free because FIFO_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        pop        = 1'b0;
        next_frame = 1'b0;
        bit_end    = (baud_q == '0);

        if (state_q != IDLE && !bit_end) begin
            baud_d = baud_q - BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    next_frame = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = LAST_BIT;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == '0) begin
                        if (PARITY != 0) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            stop_d  = STOP_LAST;
                        end
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = 1'b1;
                    stop_d  = STOP_LAST;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == 1'b0) begin
                        tx_done_d = 1'b1;
                        if (count_q != '0) begin
                            next_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_d = stop_q - 1'b1;
                        baud_d = BAUD_RELOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Shared frame launch, so back-to-back frames leave no idle gap after the stop bits.
        if (next_frame) begin
            pop     = 1'b1;
            state_d = START;
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
            shreg_d = head;
            par_d   = (PARITY == 2) ? ~^head : ^head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign tx         = tx_q;
    assign tx_done    = tx_done_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four instances (no parity, even, odd, two stop bits).
// Writes queue expected bytes; a negedge monitor matches each frame's tx waveform at tx_done.
module tb_uart_tx_engine;

    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      wr_valid = '0;
    logic [3:0][7:0] wr_data = '0;
    logic [3:0]      wr_ready;
    logic [3:0]      tx_w;
    logic [3:0]      busy_w;
    logic [3:0]      done_w;
    logic [3:0][2:0] cnt_w;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q2[$];
    logic [7:0]  exp_q3[$];
    logic [63:0] hist [4];

    always #5 clk = ~clk;

    uart_tx_engine #(.CLK_DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid[0]), .wr_data(wr_data[0]), .wr_ready(wr_ready[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]), .tx_done(done_w[0]));
    uart_tx_engine #(.CLK_DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid[1]), .wr_data(wr_data[1]), .wr_ready(wr_ready[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]), .tx_done(done_w[1]));
    uart_tx_engine #(.CLK_DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid[2]), .wr_data(wr_data[2]), .wr_ready(wr_ready[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]), .tx_done(done_w[2]));
    uart_tx_engine #(.CLK_DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid[3]), .wr_data(wr_data[3]), .wr_ready(wr_ready[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]), .tx_done(done_w[3]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int par_mode(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int stop_bits(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    // Reference line waveform; bit 0 is the last stop-bit cycle, bit len is the idle/stop cycle before the start bit.
    function automatic logic [63:0] exp_wave(input int i, input logic [7:0] d, output int len);
        logic [15:0] bits;
        logic [63:0] w;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k + 1] = d[k];
        n = 9;
        if (par_mode(i) == 1) begin
            bits[n] = ^d;
            n++;
        end else if (par_mode(i) == 2) begin
            bits[n] = ~^d;
            n++;
        end
        n   = n + stop_bits(i);
        len = n * DIV;
        w   = '0;
        w[len] = 1'b1;
        for (int k = 0; k < len; k++) w[len - 1 - k] = bits[k / DIV];
        return w;
    endfunction

    task automatic push_exp(input int i, input logic [7:0] d);
        case (i)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            2:       exp_q2.push_back(d);
            default: exp_q3.push_back(d);
        endcase
    endtask

    task automatic score_frame(input int i);
        logic [7:0]  d;
        logic [63:0] w;
        logic [63:0] m;
        int          len;
        bit          have;
        have = 1'b0;
        d    = '0;
        case (i)
            0: if (exp_q0.size() > 0) begin d = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin d = exp_q1.pop_front(); have = 1'b1; end
            2: if (exp_q2.size() > 0) begin d = exp_q2.pop_front(); have = 1'b1; end
            default: if (exp_q3.size() > 0) begin d = exp_q3.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame dut%0d: got a tx_done, want none at t=%0t", i, $time);
        end else begin
            w = exp_wave(i, d, len);
            m = (64'd1 << (len + 1)) - 64'd1;
            check($sformatf("frame_wave dut%0d byte %02h", i, d), hist[i] & m, w);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (done_w[i]) score_frame(i);
                hist[i] <= {hist[i][62:0], tx_w[i]};
            end
        end
    end

    // Starts and ends on a negedge; the word is accepted on the posedge in between.
    task automatic write_byte(input int i, input logic [7:0] d);
        logic rdy;
        wr_data[i]  = d;
        wr_valid[i] = 1'b1;
        rdy         = wr_ready[i];
        @(posedge clk);
        if (rdy) push_exp(i, d);
        check("wr_accept", rdy, 1);
        @(negedge clk);
        wr_valid[i] = 1'b0;
        wr_data[i]  = ~d;
    endtask

    // Called on the negedge of the first start-bit cycle.
    task automatic run_frame(input int i, input int len, input int pbit);
        for (int c = 0; c <= len; c++) begin
            if (c == 0) check("start_low", tx_w[i], 0);
            if (pbit >= 0 && c == 9 * DIV + 1) check("parity_bit", tx_w[i], pbit);
            if (c == len - 1) check("done_early", done_w[i], 0);
            if (c == len) check("done_pulse", done_w[i], 1);
            if (c < len) @(negedge clk);
        end
    endtask

    task automatic drain(input int i, input int limit);
        int w = 0;
        while (busy_w[i] && w < limit) begin
            @(negedge clk);
            w++;
        end
        check("drain_bounded", (w < limit), 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq;
        logic [7:0] bd;
        logic       rdy;
        int         acc;
        int         w;
        int         st1;
        int         st2;
        int         ones;
        int         busy_seen;

        repeat (3) @(negedge clk);
        check("rst_tx", tx_w, 4'hF);
        check("rst_busy", busy_w, 0);
        check("rst_done", done_w, 0);
        check("rst_count", cnt_w, 0);
        check("rst_ready", wr_ready, 4'hF);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_tx", tx_w, 4'hF);
        check("idle_busy", busy_w, 0);

        // 0xA5, no parity: exact bit-level line pattern and tx_done 40 cycles after the start bit.
        write_byte(0, 8'hA5);
        check("pre_start_tx", tx_w[0], 1);
        check("count_after_wr", cnt_w[0], 1);
        check("busy_queued", busy_w[0], 1);
        @(negedge clk);
        seq = 10'b1101001010;
        for (int c = 0; c <= 40; c++) begin
            if (c < 40 && (c % DIV) == 1) check($sformatf("a5_bit%0d", c / DIV), tx_w[0], seq[c / DIV]);
            if (c == 39) check("a5_done_early", done_w[0], 0);
            if (c == 40) check("a5_done", done_w[0], 1);
            if (c < 40) @(negedge clk);
        end
        check("a5_back_idle_tx", tx_w[0], 1);
        check("a5_back_idle_busy", busy_w[0], 0);
        @(negedge clk);
        check("a5_done_single", done_w[0], 0);

        // Even then odd parity on 0xA5 (four ones): parity bit 0 then 1, 44-cycle frames.
        write_byte(1, 8'hA5);
        @(negedge clk);
        run_frame(1, 44, 0);
        write_byte(2, 8'hA5);
        @(negedge clk);
        run_frame(2, 44, 1);

        // Two stop bits, 0x00 then 0xFF back to back.
        write_byte(3, 8'h00);
        write_byte(3, 8'hFF);
        st1 = 0;
        st2 = 0;
        for (int c = 0; c <= 88; c++) begin
            if (c == 0) check("s2_start1", tx_w[3], 0);
            if (c >= 36 && c <= 43 && tx_w[3]) st1++;
            if (c >= 80 && c <= 87 && tx_w[3]) st2++;
            if (c == 43) check("s2_done1_early", done_w[3], 0);
            if (c == 44) begin
                check("s2_done1", done_w[3], 1);
                check("s2_start2_no_gap", tx_w[3], 0);
            end
            if (c == 87) check("s2_done2_early", done_w[3], 0);
            if (c == 88) begin
                check("s2_done2", done_w[3], 1);
                check("s2_idle_after", tx_w[3], 1);
            end
            if (c < 88) @(negedge clk);
        end
        check("s2_stop_cycles1", st1, 8);
        check("s2_stop_cycles2", st2, 8);

        // Six-cycle write burst into an idle 4-deep engine.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bd          = 8'(8'h11 * (k + 1));
            wr_data[0]  = bd;
            wr_valid[0] = 1'b1;
            rdy         = wr_ready[0];
            @(posedge clk);
            if (rdy) begin
                push_exp(0, bd);
                acc++;
            end
            @(negedge clk);
        end
        wr_valid[0] = 1'b0;
        check("burst_accepted", acc, 5);
        check("full_ready", wr_ready[0], 0);
        check("full_count", cnt_w[0], 4);
        w = 0;
        while (!wr_ready[0] && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_return_cycle", w, 36);
        check("ready_after_pop", cnt_w[0], 3);
        drain(0, 400);
        check("burst_queue_empty", exp_q0.size(), 0);

        // Write coinciding with the pop at fifo_count=2.
        write_byte(0, 8'h3C);
        write_byte(0, 8'hC3);
        write_byte(0, 8'h5A);
        repeat (38) @(negedge clk);
        check("pre_pop_count", cnt_w[0], 2);
        write_byte(0, 8'h96);
        check("simul_count", cnt_w[0], 2);
        check("simul_next_start", tx_w[0], 0);
        check("simul_done", done_w[0], 1);
        drain(0, 400);
        check("simul_queue_empty", exp_q0.size(), 0);

        // Reset during the third data bit with two words queued.
        write_byte(0, 8'h00);
        write_byte(0, 8'hFF);
        write_byte(0, 8'h81);
        repeat (12) @(negedge clk);
        check("abort_pre_count", cnt_w[0], 2);
        check("abort_pre_tx", tx_w[0], 0);
        #2 rst = 1'b0;
        #1;
        check("abort_tx", tx_w[0], 1);
        check("abort_count", cnt_w[0], 0);
        check("abort_busy", busy_w[0], 0);
        check("abort_ready", wr_ready[0], 1);
        check("abort_done", done_w[0], 0);
        exp_q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ones      = 0;
        busy_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_w[0]) ones++;
            if (busy_w[0]) busy_seen++;
        end
        check("post_rst_tx_high", ones, 60);
        check("post_rst_busy", busy_seen, 0);
        check("post_rst_count", cnt_w[0], 0);

        @(negedge clk);
        check("leftover_frames", exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
